ad_capture_packer: RTL

Triggered ADC capture block, successor to the two-sample dual-data buffer. On a rising edge of the start input it discards a programmable number of settling samples, then packs PACK consecutive DSIZE-bit samples into each output word. It emits a programmable number of words with a one-cycle valid strobe per word, flags the last word, and pulses done. It sits between the ADC front-end and the voice framing/FIFO logic in the i_ad_clk domain.

---
 rtl/ad_pkg.sv | 20 ++
 rtl/ad_word_packer.sv | 65 ++++++
 rtl/ad_capture_packer.sv | 114 +++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// Shared definitions for the triggered ADC capture packer: FSM states,
// packing range limits and lane-counter sizing.
package ad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } ad_state_t;

  localparam int PACK_MIN = 1;
  localparam int PACK_MAX = 16;

  // A single-lane packer still needs a 1-bit counter to keep the logic uniform.
  function automatic int lane_width(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/ad_word_packer.sv
// Shifts samples in from the LS lane and registers a full word every PACK
// enabled samples; the oldest sample ends up in the MS lane.
module ad_word_packer
  import ad_pkg::*;
#(
  parameter  int DSIZE  = 8,
  parameter  int PACK   = 2,
  localparam int ODSIZE = DSIZE * PACK
) (
  input  logic              i_ad_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [DSIZE-1:0]  i_sample,
  output logic              o_wrap,
  output logic [ODSIZE-1:0] o_word,
  output logic              o_strobe
);

  localparam int LW = lane_width(PACK);
  localparam logic [LW-1:0] LANE_LAST = LW'(PACK - 1);

  logic [ODSIZE-1:0] shift_reg;
  logic [ODSIZE-1:0] shift_next;
  logic [LW-1:0]     lane_reg;
  logic              lane_wrap;

  assign lane_wrap = (lane_reg == LANE_LAST);
  assign o_wrap    = i_en & ~i_clr & lane_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign shift_next[DSIZE-1:0] = i_sample;
      end else begin : g_rest
        assign shift_next[gi*DSIZE +: DSIZE] = shift_reg[(gi-1)*DSIZE +: DSIZE];
      end
    end
  endgenerate

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      lane_reg  <= '0;
      o_word    <= '0;
      o_strobe  <= 1'b0;
    end else begin
      o_strobe <= 1'b0;
      if (i_clr) begin
        lane_reg <= '0;
      end else if (i_en) begin
        shift_reg <= shift_next;
        if (lane_wrap) begin
          lane_reg <= '0;
          o_word   <= shift_next;
          o_strobe <= 1'b1;
        end else begin
          lane_reg <= lane_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ad_capture_packer.sv
// Triggered ADC capture: skips settling samples after a start edge, then
// emits a fixed number of packed words with last/done signalling.
module ad_capture_packer
  import ad_pkg::*;
#(
  parameter  int DSIZE  = 8,
  parameter  int PACK   = 2,
  localparam int ODSIZE = DSIZE * PACK
) (
  input  logic              i_ad_clk,
  input  logic              i_rst_n,
  input  logic              i_st,
  input  logic              i_abort,
  input  logic [DSIZE-1:0]  i_ad_data,
  input  logic [15:0]       i_delay,
  input  logic [15:0]       i_word_count,
  output logic [ODSIZE-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_working,
  output logic              o_done
);

  if (PACK < PACK_MIN || PACK > PACK_MAX) begin : g_bad_pack
    $error("ad_capture_packer: PACK out of range");
  end

  ad_state_t   state_reg, state_next;
  logic        st_prev_reg;
  logic [15:0] delay_reg;
  logic [15:0] count_reg;
  logic [15:0] word_cnt_reg;
  logic        last_reg;
  logic        start;
  logic        pack_en;
  logic        pack_clr;
  logic        pack_wrap;

  assign start    = (state_reg == IDLE) && i_st && !st_prev_reg && !i_abort;
  // Once the final word is out, stop feeding the packer so PACK=1 cannot overrun.
  assign pack_en  = (state_reg == CAPTURE) && !i_abort && (word_cnt_reg != count_reg);
  assign pack_clr = (state_reg != CAPTURE);

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (i_word_count == 16'd0) state_next = DONE;
          else if (i_delay != 16'd0) state_next = DELAY;
          else                       state_next = CAPTURE;
        end
      end
      DELAY: begin
        if (i_abort)                     state_next = IDLE;
        else if (delay_reg == 16'd1)     state_next = CAPTURE;
      end
      CAPTURE: begin
        if (i_abort)                     state_next = IDLE;
        else if (word_cnt_reg == count_reg) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_working = (state_reg != IDLE);
    o_done    = (state_reg == DONE) && !i_abort;
  end

  always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_prev_reg  <= 1'b0;
      delay_reg    <= '0;
      count_reg    <= '0;
      word_cnt_reg <= '0;
      last_reg     <= 1'b0;
    end else begin
      st_prev_reg <= i_st;
      last_reg    <= pack_wrap && (word_cnt_reg == count_reg - 16'd1);
      if (start) begin
        delay_reg    <= i_delay;
        count_reg    <= i_word_count;
        word_cnt_reg <= '0;
      end else begin
        if (state_reg == DELAY) delay_reg <= delay_reg - 16'd1;
        if (pack_wrap)          word_cnt_reg <= word_cnt_reg + 16'd1;
      end
    end
  end

  ad_word_packer #(
    .DSIZE (DSIZE),
    .PACK  (PACK)
  ) u_packer (
    .i_ad_clk (i_ad_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (pack_en),
    .i_clr    (pack_clr),
    .i_sample (i_ad_data),
    .o_wrap   (pack_wrap),
    .o_word   (o_data),
    .o_strobe (o_valid)
  );

  assign o_last = last_reg;

endmodule
